// File: rtl/cavlc_bitstream_packer.sv
// -----------------------------------------------------------------------------
// cavlc_bitstream_packer
//
// Packs variable-length CAVLC codewords (coeff_token, trailing-ones signs,
// level prefix/suffix, total_zeros, run_before) MSB-first into fixed OUT_W-bit
// words for the NAL/RBSP writer. A flush drains every complete word, pads the
// final partial word with PAD_BIT and marks it with word_last.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   code_valid  codeword present
//   code_ready  packer can accept a codeword this cycle
//   code_bits   codeword, right-aligned; bits at or above code_len ignored
//   code_len    codeword length 0..16 (17..31 are treated as 16)
//   flush       single-cycle request to drain and pad
//   word_valid  output word present
//   word_ready  downstream accepts the word
//   word_data   packed word, first bit in the MSB
//   word_last   qualifies the final, padded word of a flush
//   flush_done  one-cycle pulse when the flush completes
//   fill_level  bits held in the accumulator
// -----------------------------------------------------------------------------
module cavlc_bitstream_packer #(
    parameter int OUT_W   = 16,
    parameter bit PAD_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    output logic             code_ready,
    input  logic [OUT_W-1:0] code_bits,
    input  logic [4:0]       code_len,
    input  logic             flush,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [OUT_W-1:0] word_data,
    output logic             word_last,
    output logic             flush_done,
    output logic [4:0]       fill_level
);

    localparam int ACC_W  = 2 * OUT_W;
    localparam int FILL_W = $clog2(ACC_W + 1);

    typedef logic [FILL_W-1:0] fill_t;

    localparam fill_t WORD_BITS = fill_t'(OUT_W);
    localparam fill_t FILL_MAX  = fill_t'(31);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        PAD,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;

    // Valid bits live at acc[ACC_W-1 -: fill]; everything below is zero.
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  acc_shifted;
    logic [ACC_W-1:0]  code_placed;
    fill_t             fill;
    fill_t             fill_next;
    fill_t             fill_shifted;
    fill_t             len_c;
    fill_t             align_shift;

    // Held low during reset so code_ready first rises the cycle after
    // reset is released, even though the state register already reads RUN.
    logic              ready_en;

    logic              out_free;
    logic              accept;
    logic              emit;
    logic              load_pad;

    logic [OUT_W-1:0]  code_aligned;
    logic [OUT_W-1:0]  pad_mask;
    logic [OUT_W-1:0]  pad_word;

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign out_free   = !word_valid || word_ready;
    // fill <= OUT_W guarantees fill + len never exceeds the accumulator.
    assign code_ready = ready_en && (state == RUN) && (fill <= WORD_BITS);
    assign accept     = code_valid && code_ready;

    // The port is five bits wide; a completely full accumulator reads as 31.
    assign fill_level = (fill > FILL_MAX) ? 5'd31 : 5'(fill);

    // -------------------------------------------------------------------------
    // Next-state and control
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        load_pad   = 1'b0;
        flush_done = 1'b0;

        unique case (state)
            RUN: begin
                emit = (fill >= WORD_BITS) && out_free;
                // A code accepted alongside flush is still appended below.
                if (flush) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                if (fill >= WORD_BITS) begin
                    emit = out_free;
                end else if (out_free) begin
                    state_next = (fill != '0) ? PAD : DONE;
                end
            end

            PAD: begin
                if (out_free) begin
                    load_pad   = 1'b1;
                    state_next = DONE;
                end
            end

            DONE: begin
                // Completion waits for the last word to be handshaken.
                if (!word_valid) begin
                    flush_done = 1'b1;
                    state_next = RUN;
                end
            end

            default: state_next = RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // Accumulator datapath
    // -------------------------------------------------------------------------
    always_comb begin
        if (int'(code_len) > OUT_W) begin
            len_c = WORD_BITS;
        end else begin
            len_c = fill_t'(code_len);
        end

        // Left-aligning the code in an OUT_W field discards the ignored upper
        // bits; len 0 shifts everything out and appends nothing.
        align_shift  = WORD_BITS - len_c;
        code_aligned = code_bits << align_shift;

        // The outgoing word is removed before the new code is appended, so
        // the code lands directly below whatever remains.
        acc_shifted  = emit ? (acc << OUT_W) : acc;
        fill_shifted = emit ? (fill - WORD_BITS) : fill;
        code_placed  = {code_aligned, {OUT_W{1'b0}}} >> fill_shifted;

        acc_next  = acc_shifted;
        fill_next = fill_shifted;
        if (accept) begin
            acc_next  = acc_shifted | code_placed;
            fill_next = fill_shifted + len_c;
        end
        if (load_pad) begin
            acc_next  = '0;
            fill_next = '0;
        end

        // Only reached with fill < OUT_W: mask covers the unused LSBs.
        pad_mask = {OUT_W{1'b1}} >> fill;
        if (PAD_BIT) begin
            pad_word = acc[ACC_W-1 -: OUT_W] | pad_mask;
        end else begin
            pad_word = acc[ACC_W-1 -: OUT_W] & ~pad_mask;
        end
    end

    // -------------------------------------------------------------------------
    // State, accumulator and output register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            acc        <= '0;
            fill       <= '0;
            ready_en   <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_last  <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            fill     <= fill_next;
            ready_en <= 1'b1;

            // A word is only loaded when the register is free, so an
            // unaccepted word is held stable until word_ready.
            if (emit) begin
                word_data  <= acc[ACC_W-1 -: OUT_W];
                word_valid <= 1'b1;
                word_last  <= 1'b0;
            end else if (load_pad) begin
                word_data  <= pad_word;
                word_valid <= 1'b1;
                word_last  <= 1'b1;
            end else if (word_ready) begin
                word_valid <= 1'b0;
                word_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cavlc_bitstream_packer.sv
// -----------------------------------------------------------------------------
// tb_cavlc_bitstream_packer
//
// Directed bench for cavlc_bitstream_packer. Two instances share stimulus:
// dut uses PAD_BIT = 0, dut1 uses PAD_BIT = 1. Inputs change on the falling
// edge and outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_cavlc_bitstream_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [15:0] code_bits;
    logic [4:0]  code_len;
    logic        flush;
    logic        word_ready;

    logic        code_ready,  code_ready1;
    logic        word_valid,  word_valid1;
    logic [15:0] word_data,   word_data1;
    logic        word_last,   word_last1;
    logic        flush_done,  flush_done1;
    logic [4:0]  fill_level,  fill_level1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cavlc_bitstream_packer #(.OUT_W(16), .PAD_BIT(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_bits  (code_bits),
        .code_len   (code_len),
        .flush      (flush),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_last  (word_last),
        .flush_done (flush_done),
        .fill_level (fill_level)
    );

    cavlc_bitstream_packer #(.OUT_W(16), .PAD_BIT(1'b1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code_ready (code_ready1),
        .code_bits  (code_bits),
        .code_len   (code_len),
        .flush      (flush),
        .word_valid (word_valid1),
        .word_ready (word_ready),
        .word_data  (word_data1),
        .word_last  (word_last1),
        .flush_done (flush_done1),
        .fill_level (fill_level1)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] b, input logic [4:0] l);
        code_valid = v;
        code_bits  = b;
        code_len   = l;
    endtask

    // Waits (bounded) for word_valid on dut; returns at that falling edge.
    task automatic wait_word(output bit got, output logic [15:0] d0, output logic l0,
                             output logic [15:0] d1, output logic l1);
        got = 1'b0;
        d0  = '0;
        l0  = 1'b0;
        d1  = '0;
        l1  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (word_valid) begin
                got = 1'b1;
                d0  = word_data;
                l0  = word_last;
                d1  = word_data1;
                l1  = word_last1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        word_ready = 1'b0;
        drive(1'b0, 16'h0, 5'd0);
        repeat (2) step();
        checks++;
        if ({code_ready, word_valid, word_last, flush_done, fill_level, word_data} !== 25'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b l=%b fd=%b fill=%0d d=%h expected all 0",
                     code_ready, word_valid, word_last, flush_done, fill_level, word_data);
        end
        checks++;
        if ({code_ready1, word_valid1, word_last1, flush_done1, fill_level1, word_data1} !== 25'h0) begin
            errors++;
            $display("FAIL reset_outputs_pad1: got rdy=%b v=%b d=%h expected all 0",
                     code_ready1, word_valid1, word_data1);
        end
        reset = 1'b0;
        step();
        checks++;
        if (code_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: got %b expected 1", code_ready);
        end
    endtask

    task automatic test_word_packing();
        word_ready = 1'b1;
        // Upper bits are garbage and must be ignored.
        drive(1'b1, 16'hFFFD, 5'd3);  step();
        drive(1'b1, 16'hFFE3, 5'd5);  step();
        drive(1'b1, 16'h12A5, 5'd8);  step();
        drive(1'b0, 16'h0, 5'd0);
        checks++;
        if (word_valid !== 1'b0 || fill_level !== 5'd16) begin
            errors++;
            $display("FAIL pack_n1: got v=%b fill=%0d expected v=0 fill=16", word_valid, fill_level);
        end
        step();
        checks++;
        if (word_valid !== 1'b1 || word_data !== 16'hA3A5 || word_last !== 1'b0) begin
            errors++;
            $display("FAIL pack_word: got v=%b d=%h l=%b expected v=1 d=a3a5 l=0",
                     word_valid, word_data, word_last);
        end
        checks++;
        if (fill_level !== 5'd0) begin
            errors++;
            $display("FAIL pack_fill: got %0d expected 0", fill_level);
        end
        repeat (2) begin
            step();
            checks++;
            if (word_valid !== 1'b0) begin
                errors++;
                $display("FAIL pack_single: got v=%b d=%h expected v=0", word_valid, word_data);
            end
        end
    endtask

    task automatic test_backpressure();
        bit          got;
        logic [15:0] d0, d1;
        logic        l0, l1;
        word_ready = 1'b0;
        drive(1'b1, 16'h0011, 5'd8);  step();
        drive(1'b1, 16'h0022, 5'd8);  step();
        drive(1'b1, 16'h0033, 5'd8);  step();
        drive(1'b1, 16'h0044, 5'd8);  step();
        checks++;
        if (code_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_at16: got %b expected 1", code_ready);
        end
        drive(1'b1, 16'h0055, 5'd8);  step();
        drive(1'b0, 16'h0, 5'd0);
        checks++;
        if (code_ready !== 1'b0 || fill_level !== 5'd24) begin
            errors++;
            $display("FAIL bp_stall: got rdy=%b fill=%0d expected rdy=0 fill=24", code_ready, fill_level);
        end
        repeat (2) step();
        checks++;
        if (word_valid !== 1'b1 || word_data !== 16'h1122 || fill_level !== 5'd24) begin
            errors++;
            $display("FAIL bp_hold: got v=%b d=%h fill=%0d expected v=1 d=1122 fill=24",
                     word_valid, word_data, fill_level);
        end
        word_ready = 1'b1;
        step();
        checks++;
        if (word_valid !== 1'b1 || word_data !== 16'h3344 || fill_level !== 5'd8 || code_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: got v=%b d=%h fill=%0d rdy=%b expected v=1 d=3344 fill=8 rdy=1",
                     word_valid, word_data, fill_level, code_ready);
        end
        step();
        checks++;
        if (word_valid !== 1'b0 || fill_level !== 5'd8) begin
            errors++;
            $display("FAIL bp_drained: got v=%b fill=%0d expected v=0 fill=8", word_valid, fill_level);
        end
        // The remaining 8'h55 must come out intact on a flush.
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_word(got, d0, l0, d1, l1);
        checks++;
        if (!got || d0 !== 16'h5500 || l0 !== 1'b1) begin
            errors++;
            $display("FAIL bp_tail: got seen=%b d=%h l=%b expected seen=1 d=5500 l=1", got, d0, l0);
        end
        step();
        checks++;
        if (flush_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_flush_done: got %b expected 1", flush_done);
        end
        step();
    endtask

    task automatic test_padded_flush();
        bit          got;
        logic [15:0] d0, d1;
        logic        l0, l1;
        word_ready = 1'b1;
        drive(1'b1, 16'h0016, 5'd5);  step();
        drive(1'b0, 16'h0, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_word(got, d0, l0, d1, l1);
        checks++;
        if (!got || d0 !== 16'hB000 || l0 !== 1'b1) begin
            errors++;
            $display("FAIL pad0_word: got seen=%b d=%h l=%b expected seen=1 d=b000 l=1", got, d0, l0);
        end
        checks++;
        if (d1 !== 16'hB7FF || l1 !== 1'b1) begin
            errors++;
            $display("FAIL pad1_word: got d=%h l=%b expected d=b7ff l=1", d1, l1);
        end
        step();
        checks++;
        if (flush_done !== 1'b1 || word_valid !== 1'b0 || word_last !== 1'b0) begin
            errors++;
            $display("FAIL pad_done: got fd=%b v=%b l=%b expected fd=1 v=0 l=0",
                     flush_done, word_valid, word_last);
        end
        step();
        checks++;
        if (flush_done !== 1'b0 || code_ready !== 1'b1) begin
            errors++;
            $display("FAIL pad_after: got fd=%b rdy=%b expected fd=0 rdy=1", flush_done, code_ready);
        end
    endtask

    task automatic test_empty_flush();
        bit seen;
        seen = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (word_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_no_word: got v=%b expected 0", word_valid);
            end
            if (flush_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL empty_done: got no flush_done expected pulse within 3 cycles");
        end
        step();
        checks++;
        if (flush_done !== 1'b0 || code_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_after: got fd=%b rdy=%b expected fd=0 rdy=1", flush_done, code_ready);
        end
    endtask

    task automatic test_len_edges();
        word_ready = 1'b1;
        drive(1'b1, 16'hFFFF, 5'd0);  step();
        drive(1'b0, 16'h0, 5'd0);
        checks++;
        if (fill_level !== 5'd0 || code_ready !== 1'b1) begin
            errors++;
            $display("FAIL len0_noop: got fill=%0d rdy=%b expected fill=0 rdy=1", fill_level, code_ready);
        end
        drive(1'b1, 16'h1234, 5'd20);  step();
        drive(1'b0, 16'h0, 5'd0);
        checks++;
        if (fill_level !== 5'd16) begin
            errors++;
            $display("FAIL len_clamp_fill: got %0d expected 16", fill_level);
        end
        step();
        checks++;
        if (word_valid !== 1'b1 || word_data !== 16'h1234 || fill_level !== 5'd0) begin
            errors++;
            $display("FAIL len_clamp_word: got v=%b d=%h fill=%0d expected v=1 d=1234 fill=0",
                     word_valid, word_data, fill_level);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int          nwords;
        int          first_c;
        int          last_c;
        logic [15:0] exp_w;
        nwords  = 0;
        first_c = -1;
        last_c  = -1;
        word_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (word_valid) begin
                exp_w = (nwords % 2 == 0) ? 16'hFFFF : 16'h0000;
                checks++;
                if (word_data !== exp_w) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %h expected %h", nwords, word_data, exp_w);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                nwords++;
            end
            if (c < 8) begin
                checks++;
                if (code_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready%0d: got %b expected 1", c, code_ready);
                end
                drive(1'b1, (c % 2 == 0) ? 16'hFFFF : 16'h0000, 5'd16);
            end else begin
                drive(1'b0, 16'h0, 5'd0);
            end
            step();
        end
        checks++;
        if (nwords != 8 || (last_c - first_c) != 7) begin
            errors++;
            $display("FAIL b2b_rate: got words=%0d span=%0d expected words=8 span=7",
                     nwords, last_c - first_c);
        end
        checks++;
        if (fill_level !== 5'd0) begin
            errors++;
            $display("FAIL b2b_fill: got %0d expected 0", fill_level);
        end
    endtask

    task automatic test_reset_mid();
        bit          got;
        logic [15:0] d0, d1;
        logic        l0, l1;
        word_ready = 1'b0;
        drive(1'b1, 16'hABCD, 5'd16);  step();
        drive(1'b1, 16'h0123, 5'd12);  step();
        drive(1'b0, 16'h0, 5'd0);
        checks++;
        if (word_valid !== 1'b1 || fill_level !== 5'd12) begin
            errors++;
            $display("FAIL mid_setup: got v=%b fill=%0d expected v=1 fill=12", word_valid, fill_level);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({code_ready, word_valid, word_last, flush_done, fill_level, word_data} !== 25'h0) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b v=%b l=%b fd=%b fill=%0d d=%h expected all 0",
                     code_ready, word_valid, word_last, flush_done, fill_level, word_data);
        end
        reset = 1'b0;
        word_ready = 1'b1;
        step();
        checks++;
        if (code_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready: got %b expected 1", code_ready);
        end
        // Code accepted in the same cycle as flush is included in the drain.
        drive(1'b1, 16'h000F, 5'd4);
        flush = 1'b1;
        step();
        drive(1'b0, 16'h0, 5'd0);
        flush = 1'b0;
        wait_word(got, d0, l0, d1, l1);
        checks++;
        if (!got || d0 !== 16'hF000 || l0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_clean: got seen=%b d=%h l=%b expected seen=1 d=f000 l=1", got, d0, l0);
        end
        checks++;
        if (d1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL mid_clean_pad1: got %h expected ffff", d1);
        end
        step();
        checks++;
        if (flush_done !== 1'b1) begin
            errors++;
            $display("FAIL mid_flush_done: got %b expected 1", flush_done);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_word_packing();
        test_backpressure();
        test_padded_flush();
        test_empty_flush();
        test_len_edges();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
